// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock: mode encodings, BCD helpers.
package clock_pkg;

  localparam int BCD_W = 4;

  // Mode encodings (11 is never driven)
  localparam logic [1:0] MODE_RUN      = 2'b00;
  localparam logic [1:0] MODE_SET_HOUR = 2'b01;
  localparam logic [1:0] MODE_SET_MIN  = 2'b10;

  typedef logic [2*BCD_W-1:0] bcd2_t;

  // Convert a small decimal constant (0..99) into a two-digit BCD pair.
  function automatic bcd2_t int2bcd(input int n);
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] units;
    tens  = BCD_W'(n / 10);
    units = BCD_W'(n % 10);
    return {tens, units};
  endfunction

  // Increment a two-digit BCD value; at 'max' it wraps to 00.
  // Result is {wrap, next}.
  function automatic logic [2*BCD_W:0] bcd2_inc(input bcd2_t value, input bcd2_t max);
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] units;
    tens  = value[2*BCD_W-1:BCD_W];
    units = value[BCD_W-1:0];
    if (value == max) begin
      return {1'b1, bcd2_t'(0)};
    end else if (units == BCD_W'(9)) begin
      return {1'b0, tens + BCD_W'(1), BCD_W'(0)};
    end else begin
      return {1'b0, tens, units + BCD_W'(1)};
    end
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps from MAX back to 00. 'wrap' flags, in the
// cycle the count is enabled at MAX, that this edge rolls the count over.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter bcd2_t MAX = 8'h59
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  output bcd2_t q,
  output logic  wrap
);

  bcd2_t               count_reg;
  logic [2*BCD_W:0]    inc_res;

  // Next BCD value and wrap flag for the current count
  always_comb begin
    inc_res = bcd2_inc(count_reg, MAX);
  end

  assign wrap = en & inc_res[2*BCD_W];
  assign q    = count_reg;

  // Count register, advances only when enabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= inc_res[2*BCD_W-1:0];
    end
  end

endmodule

// File: rtl/hms_time_keeper.sv
// Minute/hour stage of the digital clock. Consumes the seconds carry, keeps
// BCD minutes and hours, and runs the RUN/SET_HOUR/SET_MIN mode FSM that lets
// the user set the time with mode/increment button pulses.
module hms_time_keeper
  import clock_pkg::*;
#(
  parameter int HOUR_MOD = 24,
  parameter int MIN_MOD  = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_carry,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic [1:0] mode,
  output logic       day_co,
  output logic       chime,
  output logic       sec_clr
);

  localparam bcd2_t MIN_MAX  = int2bcd(MIN_MOD - 1);
  localparam bcd2_t HOUR_MAX = int2bcd(HOUR_MOD - 1);

  logic [1:0] mode_reg;
  logic [1:0] mode_next;
  logic       day_co_reg;
  logic       chime_reg;
  logic       sec_clr_reg;

  logic       in_run;
  logic       inc_ok;
  logic       min_en;
  logic       hour_en;
  logic       min_wrap;
  logic       hour_wrap;

  assign in_run = (mode_reg == MODE_RUN);
  // A mode press in the same cycle swallows the increment
  assign inc_ok = btn_inc & ~btn_mode;

  // Minutes tick on seconds carry in RUN, or on increment while setting minutes
  assign min_en  = (in_run & sec_carry) | ((mode_reg == MODE_SET_MIN) & inc_ok);
  // Hours tick on minute rollover in RUN only, or on increment while setting hours
  assign hour_en = (in_run & min_wrap) | ((mode_reg == MODE_SET_HOUR) & inc_ok);

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk  (clk),
    .rst  (rst),
    .en   (min_en),
    .q    (min_bcd),
    .wrap (min_wrap)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk  (clk),
    .rst  (rst),
    .en   (hour_en),
    .q    (hour_bcd),
    .wrap (hour_wrap)
  );

  // Mode sequencing: each btn_mode pulse steps to the next mode
  always_comb begin
    mode_next = mode_reg;
    if (btn_mode) begin
      case (mode_reg)
        MODE_RUN:      mode_next = MODE_SET_HOUR;
        MODE_SET_HOUR: mode_next = MODE_SET_MIN;
        MODE_SET_MIN:  mode_next = MODE_RUN;
        default:       mode_next = MODE_RUN;
      endcase
    end
  end

  // Mode register and one-cycle strobes, all registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_reg    <= MODE_RUN;
      day_co_reg  <= 1'b0;
      chime_reg   <= 1'b0;
      sec_clr_reg <= 1'b0;
    end else begin
      mode_reg    <= mode_next;
      chime_reg   <= in_run & min_wrap;
      day_co_reg  <= in_run & min_wrap & hour_wrap;
      sec_clr_reg <= (mode_reg == MODE_SET_MIN) & btn_mode;
    end
  end

  assign mode    = mode_reg;
  assign day_co  = day_co_reg;
  assign chime   = chime_reg;
  assign sec_clr = sec_clr_reg;

endmodule

// File: tb/tb_hms_time_keeper.sv
// Self-checking bench: a 24-hour and a 12-hour instance share stimulus and are
// compared every cycle against an integer-arithmetic reference model.
module tb_hms_time_keeper;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sec_carry = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;

  logic [7:0] min_a, hour_a, min_b, hour_b;
  logic [1:0] mode_a, mode_b;
  logic       day_a, chime_a, clr_a, day_b, chime_b, clr_b;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: index 0 = 24-hour, 1 = 12-hour
  int m_min[2], m_hour[2], m_mode[2];
  bit m_day[2], m_chime[2], m_clr[2];
  int hour_mod[2] = '{24, 12};

  always #5 clk = ~clk;

  hms_time_keeper #(.HOUR_MOD(24), .MIN_MOD(60)) dut24 (
    .clk(clk), .rst(rst), .sec_carry(sec_carry), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .min_bcd(min_a), .hour_bcd(hour_a), .mode(mode_a),
    .day_co(day_a), .chime(chime_a), .sec_clr(clr_a)
  );

  hms_time_keeper #(.HOUR_MOD(12), .MIN_MOD(60)) dut12 (
    .clk(clk), .rst(rst), .sec_carry(sec_carry), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .min_bcd(min_b), .hour_bcd(hour_b), .mode(mode_b),
    .day_co(day_b), .chime(chime_b), .sec_clr(clr_b)
  );

  function automatic logic [7:0] to_bcd(input int n);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_min[k] = 0; m_hour[k] = 0; m_mode[k] = 0;
      m_day[k] = 0; m_chime[k] = 0; m_clr[k] = 0;
    end
  endtask

  // One clock of the behavioural clock model
  task automatic model_step(input bit sc, input bit bm, input bit bi);
    for (int k = 0; k < 2; k++) begin
      m_day[k] = 0; m_chime[k] = 0; m_clr[k] = 0;
      case (m_mode[k])
        0: begin
          if (sc) begin
            m_min[k]++;
            if (m_min[k] == 60) begin
              m_min[k] = 0;
              m_chime[k] = 1;
              m_hour[k]++;
              if (m_hour[k] == hour_mod[k]) begin
                m_hour[k] = 0;
                m_day[k] = 1;
              end
            end
          end
          if (bm) m_mode[k] = 1;
        end
        1: begin
          if (bm) m_mode[k] = 2;
          else if (bi) m_hour[k] = (m_hour[k] + 1) % hour_mod[k];
        end
        default: begin
          if (bm) begin
            m_mode[k] = 0;
            m_clr[k] = 1;
          end else if (bi) m_min[k] = (m_min[k] + 1) % 60;
        end
      endcase
    end
  endtask

  task automatic check_all();
    check("min24",   min_a,          to_bcd(m_min[0]));
    check("hour24",  hour_a,         to_bcd(m_hour[0]));
    check("mode24",  8'(mode_a),     8'(m_mode[0]));
    check("day24",   8'(day_a),      8'(m_day[0]));
    check("chime24", 8'(chime_a),    8'(m_chime[0]));
    check("clr24",   8'(clr_a),      8'(m_clr[0]));
    check("min12",   min_b,          to_bcd(m_min[1]));
    check("hour12",  hour_b,         to_bcd(m_hour[1]));
    check("mode12",  8'(mode_b),     8'(m_mode[1]));
    check("day12",   8'(day_b),      8'(m_day[1]));
    check("chime12", 8'(chime_b),    8'(m_chime[1]));
    check("clr12",   8'(clr_b),      8'(m_clr[1]));
  endtask

  // Drive one cycle of inputs (called at posedge+1), then check after the edge
  task automatic step(input bit sc, input bit bm, input bit bi);
    sec_carry = sc; btn_mode = bm; btn_inc = bi;
    @(posedge clk);
    #1;
    model_step(sc, bm, bi);
    sec_carry = 0; btn_mode = 0; btn_inc = 0;
    check_all();
  endtask

  task automatic async_reset();
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  int chime_cnt;
  int day_cnt;

  initial begin
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    check_all();

    // Reset mid-count and mid-set
    repeat (5) step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 1);
    async_reset();
    check("rst_mode", 8'(mode_a), 8'h00);
    check("rst_min", min_a, 8'h00);
    $display("reset: min=%h hour=%h mode=%0d", min_a, hour_a, mode_a);

    // 60 seconds carries: 00:00 -> 01:00, exactly one chime, no day carry
    chime_cnt = 0; day_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      step(1, 0, 0);
      chime_cnt += chime_a; day_cnt += day_a;
      step(0, 0, 0);
    end
    check("run_hour", hour_a, 8'h01);
    check("run_chime_cnt", 8'(chime_cnt), 8'd1);
    check("run_day_cnt", 8'(day_cnt), 8'd0);
    $display("run carry: %h:%h chimes=%0d", hour_a, min_a, chime_cnt);

    // Set to 23:59 (12-hour instance lands on 11:59), then roll over the day
    async_reset();
    step(0, 1, 0);
    repeat (23) step(0, 0, 1);
    step(0, 1, 0);
    repeat (59) step(0, 0, 1);
    step(0, 1, 0);
    check("set_clr", 8'(clr_a), 8'h01);
    step(0, 0, 0);
    check("set_clr_once", 8'(clr_a), 8'h00);
    check("set_time24", {hour_a, min_a} == 16'h2359 ? 8'h01 : 8'h00, 8'h01);
    check("set_time12", {hour_b, min_b} == 16'h1159 ? 8'h01 : 8'h00, 8'h01);
    step(1, 0, 0);
    check("day24_pulse", {7'd0, day_a & chime_a}, 8'h01);
    check("day12_pulse", {7'd0, day_b & chime_b}, 8'h01);
    $display("day rollover: %h:%h day_co=%0d chime=%0d", hour_a, min_a, day_a, chime_a);

    // Set wraps: hours 23 -> 00 and minutes 59 -> 00 without carries
    step(0, 1, 0);
    repeat (24) step(0, 0, 1);
    check("sethour_wrap", hour_a, 8'h00);
    step(0, 1, 0);
    repeat (60) step(0, 0, 1);
    check("setmin_wrap", min_a, 8'h00);
    step(0, 1, 0);
    $display("set wrap: %h:%h", hour_a, min_a);

    // Collisions
    step(1, 1, 0);                        // carry applied, then SET_HOUR
    repeat (5) step(0, 0, 1);
    step(1, 0, 0);                        // ignored while setting
    step(0, 1, 1);                        // mode wins, inc discarded
    check("collide_hour", hour_a, 8'h05);
    step(1, 0, 0);
    step(1, 0, 1);
    step(0, 1, 0);
    $display("collisions: %h:%h mode=%0d", hour_a, min_a, mode_a);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(3, 0) == 0, $urandom_range(15, 0) == 0, $urandom_range(2, 0) == 0);
    end
    $display("random: %h:%h mode=%0d", hour_a, min_a, mode_a);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
